// File: rtl/skid_buffer_pkg.sv
// Shared definitions for the skid buffer: default data width, enable levels
// and FSM state codes.
package skid_buffer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/skid_buffer_flopen.sv
// Enable register used for the skid buffer head and skid storage.
module skid_buffer_flopen
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: pure data storage carries no reset; the FSM decides whether its contents are meaningful.
  always_ff @(posedge clk) begin
    if (en == ENABLE) q <= d;
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer feeding a downstream enable-register stage.
// Optional transfer counter enabled by defining SKID_STATS_EN.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_en,
  output logic [WIDTH-1:0] out_data
`ifdef SKID_STATS_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  skid_state_e      state_q, state_d;
  logic             head_en, skid_en;
  logic [WIDTH-1:0] head_d, head_q, skid_q;
  logic             push, pop;

  assign in_ready = !reset && (state_q != SKID_FULL);
  assign out_en   = (state_q != SKID_EMPTY && out_ready && !reset) ? ENABLE : DISABLE;
  assign push     = in_valid && in_ready;
  assign pop      = (out_en == ENABLE);
  assign out_data = head_q;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    head_en = DISABLE;
    skid_en = DISABLE;
    head_d  = in_data;
    unique case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d = SKID_ONE;
          head_en = ENABLE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          head_en = ENABLE;
        end else if (push) begin
          state_d = SKID_FULL;
          skid_en = ENABLE;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_d = SKID_ONE;
          head_en = ENABLE;
          head_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SKID_EMPTY;
    else       state_q <= state_d;
  end

  skid_buffer_flopen #(.WIDTH(WIDTH)) u_head (
    .clk (clk),
    .en  (head_en),
    .d   (head_d),
    .q   (head_q)
  );

  skid_buffer_flopen #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

`ifdef SKID_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb xfer_count_d = pop ? xfer_count_q + 16'd1 : xfer_count_q;

  always_ff @(posedge clk) begin
    if (reset) xfer_count_q <= 16'd0;
    else       xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Directed bench for skid_buffer: per-cycle vector table plus ordering and counter sequences.
module tb_skid_buffer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         out_en;
  logic [W-1:0] out_data;
`ifdef SKID_STATS_EN
  logic [15:0]  xfer_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  skid_buffer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_en     (out_en),
    .out_data   (out_data)
`ifdef SKID_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  typedef struct {
    logic         rst;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ir;
    logic         e_oe;
    logic         chk_d;
    logic [W-1:0] e_d;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic iv, input logic [W-1:0] d, input logic ordy,
                     input logic e_ir, input logic e_oe, input logic chk_d, input logic [W-1:0] e_d);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_oe = e_oe; v.chk_d = chk_d; v.e_d = e_d;
    vecs.push_back(v);
  endtask

  // Drive at posedge+1, compare at the following negedge, then advance one cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_words;
    int idx;
    int rx;
    int cyc;

    // rst iv  d    ordy | in_ready out_en chk_d out_data
    // Reset held 2 cycles with in_valid high; nothing may be pushed.
    add(1, 1, 8'hAA, 1,   0, 0, 0, 8'h00);
    add(1, 1, 8'hAA, 1,   0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0,   1, 0, 0, 8'h00);
    // Streaming 10,20,30 with out_ready high.
    add(0, 1, 8'd10, 1,   1, 0, 0, 8'h00);
    add(0, 1, 8'd20, 1,   1, 1, 1, 8'd10);
    add(0, 1, 8'd30, 1,   1, 1, 1, 8'd20);
    add(0, 0, 8'd00, 1,   1, 1, 1, 8'd30);
    add(0, 0, 8'd00, 1,   1, 0, 0, 8'h00);
    // Backpressure: fill to FULL, 30 held off, then drain in order.
    add(0, 1, 8'd10, 0,   1, 0, 0, 8'h00);
    add(0, 1, 8'd20, 0,   1, 0, 1, 8'd10);
    add(0, 1, 8'd30, 0,   0, 0, 1, 8'd10);
    add(0, 1, 8'd30, 1,   0, 1, 1, 8'd10);
    add(0, 1, 8'd30, 1,   1, 1, 1, 8'd20);
    add(0, 0, 8'd00, 1,   1, 1, 1, 8'd30);
    add(0, 0, 8'd00, 0,   1, 0, 0, 8'h00);
    // Simultaneous push and pop while in ONE.
    add(0, 1, 8'd10, 0,   1, 0, 0, 8'h00);
    add(0, 1, 8'd20, 1,   1, 1, 1, 8'd10);
    add(0, 0, 8'd00, 0,   1, 0, 1, 8'd20);
    add(0, 0, 8'd00, 1,   1, 1, 1, 8'd20);
    // Reset while FULL discards both words.
    add(0, 1, 8'd10, 0,   1, 0, 0, 8'h00);
    add(0, 1, 8'd20, 0,   1, 0, 1, 8'd10);
    add(0, 0, 8'd00, 0,   0, 0, 1, 8'd10);
    add(1, 0, 8'd00, 1,   0, 0, 0, 8'h00);
    add(0, 0, 8'd00, 1,   1, 0, 0, 8'h00);
    add(0, 0, 8'd00, 1,   1, 0, 0, 8'h00);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d out_en", i), out_en, vecs[i].e_oe);
      if (vecs[i].chk_d) check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_d);
      next_cycle();
    end

    // Ordering under irregular in_valid/out_ready patterns against a reference queue.
    n_words = 60;
    idx = 0;
    rx = 0;
    for (int c = 0; c < 300; c++) begin
      reset     = 1'b0;
      in_valid  = (idx < n_words) && ($urandom_range(0, 3) != 0);
      in_data   = W'(idx * 7 + 3);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_en) begin
        check("order depth", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          check($sformatf("order word%0d", rx), out_data, sb.pop_front());
          rx++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        idx++;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (rx < n_words && cyc < 20) begin
      @(negedge clk);
      if (out_en && sb.size() > 0) begin
        check($sformatf("order word%0d", rx), out_data, sb.pop_front());
        rx++;
      end
      next_cycle();
      cyc++;
    end
    check("order words received", rx, idx);
    check("order words sent", idx, n_words);

`ifdef SKID_STATS_EN
    begin
      int pops;
      reset = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h55;
      out_ready = 1'b1;
      next_cycle();
      reset = 1'b0;
      check("xfer_count after reset", xfer_count, 16'h0000);
      pops = 0;
      cyc = 0;
      while (pops < 65534 && cyc < 70000) begin
        @(negedge clk);
        if (out_en) pops++;
        next_cycle();
        cyc++;
      end
      check("preload pops", pops, 65534);
      check("xfer_count preload", xfer_count, 16'hFFFE);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        check($sformatf("wrap pop%0d out_en", k), out_en, 1);
        next_cycle();
      end
      check("xfer_count wrap", xfer_count, 16'h0000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
